// File: rtl/tx_packet_queue.sv
// Transmit packet queue: buffers packets from the byte packet buffer and launches
// them one at a time to the sorter, pacing launches by tx_done plus a guard interval.
module tx_packet_queue #(
  parameter int unsigned PACKET_WIDTH = 8,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned GUARD_CYCLES = 16
) (
  input  logic                        clk_out_base,
  input  logic                        reset,
  input  logic [PACKET_WIDTH*8-1:0]   sys_packet,
  input  logic                        send,
  input  logic                        tx_done,
  output logic [PACKET_WIDTH*8-1:0]   packet_out,
  output logic                        ready,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        overflow
);

  localparam int unsigned PW = PACKET_WIDTH * 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GUARD_CYCLES + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE, GUARD} state_t;

  state_t        state;
  logic [PW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [GW-1:0] guard_cnt;
  logic          pop_c;
  logic          push_c;

  // A full queue still accepts a push in the cycle its head is popped.
  assign pop_c  = (state == LAUNCH);
  assign push_c = send && !reset && ((count != FULL) || pop_c);

  // Queue storage; contents are don't-care after reset since pointers clear.
  always_ff @(posedge clk_out_base) begin
    if (push_c) mem[wr_ptr] <= sys_packet;
  end

  // Pointers, occupancy, overflow flag and launch FSM.
  always_ff @(posedge clk_out_base) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      guard_cnt  <= '0;
      overflow   <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b0;
      packet_out <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);

      case ({push_c, pop_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (send && !push_c) overflow <= 1'b1;

      ready <= 1'b0;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state      <= LAUNCH;
            packet_out <= mem[rd_ptr];
            ready      <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LAUNCH: begin
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
            guard_cnt <= GUARD_LOAD;
            state     <= GUARD;
          end
        end
        GUARD: begin
          if (guard_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - GW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_packet_queue.sv
// Scoreboard bench for tx_packet_queue: accepted packets are queued as they are sent
// and compared against packet_out whenever ready pulses; timing/flags checked directly.
module tb_tx_packet_queue;

  localparam int unsigned PW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned G  = 16;
  localparam int unsigned PB = PW * 8;
  localparam int unsigned CW = $clog2(D) + 1;

  logic          clk_out_base = 1'b0;
  logic          reset = 1'b1;
  logic          send = 1'b0;
  logic          tx_done = 1'b0;
  logic [PB-1:0] sys_packet = '0;
  logic [PB-1:0] packet_out;
  logic          ready;
  logic          busy;
  logic          overflow;
  logic [CW-1:0] count;

  tx_packet_queue #(.PACKET_WIDTH(PW), .DEPTH(D), .GUARD_CYCLES(G)) dut (
    .clk_out_base(clk_out_base),
    .reset       (reset),
    .sys_packet  (sys_packet),
    .send        (send),
    .tx_done     (tx_done),
    .packet_out  (packet_out),
    .ready       (ready),
    .busy        (busy),
    .count       (count),
    .overflow    (overflow)
  );

  always #5 clk_out_base = ~clk_out_base;

  int cyc = 0;
  always @(posedge clk_out_base) cyc <= cyc + 1;

  logic [PB-1:0] sb[$];
  int n_checks = 0;
  int n_fail = 0;
  int n_ready = 0;
  int last_ready_cyc = -1;

  task automatic check_eq(input string tag, input logic [PB-1:0] got, input logic [PB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Every launch is compared against the oldest accepted packet.
  always @(negedge clk_out_base) begin
    if (ready === 1'b1) begin
      n_ready++;
      last_ready_cyc = cyc;
      if (sb.size() == 0) check_eq("unexpected_ready", PB'(ready), '0);
      else                check_eq("launch_data", packet_out, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk_out_base);
    #1;
  endtask

  task automatic send_pkt(input logic [PB-1:0] d, input bit accept);
    send = 1'b1;
    sys_packet = d;
    if (accept) sb.push_back(d);
    tick();
    send = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_ready(input int start, output bit ok);
    int b = 0;
    while (n_ready <= start && b < 200) begin
      tick();
      b++;
    end
    ok = (n_ready > start);
    if (!ok) check_eq("ready_timeout", PB'(n_ready), PB'(start + 1));
  endtask

  // Serves every queued packet, starting with no launch outstanding.
  task automatic drain();
    bit ok;
    while (sb.size() > 0) begin
      wait_ready(n_ready, ok);
      if (!ok) return;
      pulse_done();
    end
    repeat (G + 2) tick();
  endtask

  function automatic logic [PB-1:0] rnd_pkt();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int s;
    int t;

    // Reset values
    tick(); tick();
    check_eq("rst_ready", PB'(ready), '0);
    check_eq("rst_busy", PB'(busy), '0);
    check_eq("rst_count", PB'(count), '0);
    check_eq("rst_overflow", PB'(overflow), '0);
    check_eq("rst_packet_out", packet_out, '0);
    tick();
    reset = 1'b0;

    // Single packet latency
    wait_until(10);
    send_pkt(64'hA500_0000_0000_0001, 1'b1);
    tick();
    check_eq("single_busy", PB'(busy), PB'(1));
    tick();
    check_eq("single_ready_cyc", PB'(last_ready_cyc), PB'(12));
    check_eq("single_count", PB'(count), '0);
    check_eq("single_pkt_out_hold", packet_out, 64'hA500_0000_0000_0001);
    pulse_done();
    repeat (G + 2) tick();
    check_eq("single_idle_busy", PB'(busy), '0);

    // Back-to-back with guard, stray tx_done in GUARD ignored
    for (int i = 0; i < 3; i++) send_pkt(rnd_pkt(), 1'b1);
    wait_until(50);
    s = n_ready;
    pulse_done();
    wait_until(55);
    pulse_done();
    wait_ready(s, ok);
    check_eq("b2b_ready_cyc", PB'(last_ready_cyc), PB'(50 + G + 2));
    pulse_done();
    drain();

    // Overflow: D+1 accepted (one launches early), remainder dropped
    for (int i = 0; i < D + 3; i++) send_pkt(rnd_pkt(), i <= D);
    check_eq("ovf_count", PB'(count), PB'(D));
    check_eq("ovf_flag", PB'(overflow), PB'(1));
    pulse_done();
    drain();
    check_eq("ovf_drained_count", PB'(count), '0);
    check_eq("ovf_sticky", PB'(overflow), PB'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("ovf_cleared", PB'(overflow), '0);

    // Push coinciding with pop while full
    for (int i = 0; i < D + 1; i++) send_pkt(rnd_pkt(), 1'b1);
    check_eq("full_count", PB'(count), PB'(D));
    tick();
    t = cyc;
    pulse_done();
    wait_until(t + G + 2);
    send_pkt(64'hC0FF_EE00_DEAD_BEEF, 1'b1);
    check_eq("pushpop_count", PB'(count), PB'(D));
    check_eq("pushpop_overflow", PB'(overflow), '0);
    pulse_done();
    drain();

    // Wrap-around over 3*D packets
    for (int b = 0; b < (3 * D) / 2; b++) begin
      send_pkt(rnd_pkt(), 1'b1);
      send_pkt(rnd_pkt(), 1'b1);
      drain();
    end
    check_eq("wrap_sb_empty", PB'(sb.size()), '0);
    check_eq("wrap_count", PB'(count), '0);

    // Reset in WAIT_DONE with two queued, plus a send during reset
    for (int i = 0; i < 3; i++) send_pkt(rnd_pkt(), 1'b1);
    tick();
    check_eq("pre_rst_count", PB'(count), PB'(2));
    sb.delete();
    reset = 1'b1;
    send = 1'b1;
    sys_packet = rnd_pkt();
    tick();
    reset = 1'b0;
    send = 1'b0;
    check_eq("post_rst_count", PB'(count), '0);
    check_eq("post_rst_busy", PB'(busy), '0);
    s = n_ready;
    repeat (30) tick();
    check_eq("post_rst_no_ready", PB'(n_ready), PB'(s));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
